dual_rail_vector_driver: RTL and testbench

//  Sequential stimulus/check engine for dual-rail static-CMOS gates (4 inputs, true+complement rails).
//  On start, walks all 16 input vectors {A,B,C,D}=0..15 and drives both rails of each.

---
 rtl/dual_rail_vector_driver.sv | 195 +++++++++++++++++++
 tb/tb_dual_rail_vector_driver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dual_rail_vector_driver.sv
// Purpose : drives all 16 dual-rail vectors into a 4-input gate, samples its output, scores it against GOLDEN.
// Latency : start -> done is 1+16*(SETTLE_CYC+1) cycles (1+16*(SETTLE_CYC+3) with DRV_SYNC_EN).
// Backpr. : none; start is ignored while busy or during FIN, and abort wins over start and over sampling.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, abort          sweep request (honoured only when idle), synchronous abort
//   dut_out               output of the gate under test
//   A..D / notA..notD     registered true / complement rails, always strictly complementary
//   busy, done            sweep in progress, 1-cycle pulse at the end of a completed sweep
//   pass, fail_count,     results of the current/last sweep; held until the next start
//   first_fail_idx, observed
//
// Optional feature: define DRV_SYNC_EN to pass dut_out through a 2-flop synchronizer before the
// compare; each DRIVE phase then lasts two extra cycles so the sampled value belongs to the held vector.

module dual_rail_vector_driver #(
    parameter int unsigned SETTLE_CYC = 4,
    parameter logic [15:0] GOLDEN     = 16'hFC51
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        dut_out,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        notA,
    output logic        notB,
    output logic        notC,
    output logic        notD,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  fail_count,
    output logic [3:0]  first_fail_idx,
    output logic [15:0] observed
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_FIN
    } state_t;

    logic samp;

`ifdef DRV_SYNC_EN
    localparam int unsigned DRIVE_CYC = SETTLE_CYC + 2;

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], dut_out};
        end
    end

    assign samp = sync_q[1];
`else
    localparam int unsigned DRIVE_CYC = SETTLE_CYC;

    assign samp = dut_out;
`endif

    // DRIVE_CYC can reach 257, so the settle counter is 9 bits wide.
    localparam logic [8:0] CNT_LAST = 9'(DRIVE_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [3:0]  rail_q, rail_d;
    logic [3:0]  nrail_q;
    logic [4:0]  fc_q, fc_d;
    logic [3:0]  ffi_q, ffi_d;
    logic [15:0] obs_q, obs_d;
    logic        pass_q, pass_d;
    logic        mism;

    // The complement rails get their own flops (loaded with ~rail_d) so that both rails
    // switch on the same clock edge instead of one trailing the other through an inverter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 9'd0;
            rail_q  <= 4'h0;
            nrail_q <= 4'hF;
            fc_q    <= 5'd0;
            ffi_q   <= 4'd0;
            obs_q   <= 16'h0000;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rail_q  <= rail_d;
            nrail_q <= ~rail_d;
            fc_q    <= fc_d;
            ffi_q   <= ffi_d;
            obs_q   <= obs_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rail_d  = rail_q;
        fc_d    = fc_q;
        ffi_d   = ffi_q;
        obs_d   = obs_q;
        pass_d  = pass_q;
        mism    = samp ^ GOLDEN[idx_q];

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_DRIVE;
                    idx_d   = 4'd0;
                    cnt_d   = 9'd0;
                    rail_d  = 4'h0;
                    fc_d    = 5'd0;
                    ffi_d   = 4'd0;
                    obs_d   = 16'h0000;
                    pass_d  = 1'b0;
                end
            end

            S_DRIVE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    rail_d  = 4'h0;
                    pass_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end

            S_SAMPLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    rail_d  = 4'h0;
                    pass_d  = 1'b0;
                end else begin
                    obs_d[idx_q] = samp;
                    if (mism) begin
                        fc_d = fc_q + 5'd1;
                        if (fc_q == 5'd0) begin
                            ffi_d = idx_q;
                        end
                    end
                    if (idx_q == 4'd15) begin
                        // pass is registered on FIN entry so it is valid alongside done.
                        state_d = S_FIN;
                        pass_d  = (fc_d == 5'd0);
                    end else begin
                        state_d = S_DRIVE;
                        idx_d   = idx_q + 4'd1;
                        rail_d  = idx_q + 4'd1;
                        cnt_d   = 9'd0;
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
                rail_d  = 4'h0;
            end

            default: begin
                state_d = S_IDLE;
                rail_d  = 4'h0;
            end
        endcase
    end

    assign {A, B, C, D}             = rail_q;
    assign {notA, notB, notC, notD} = nrail_q;
    assign busy                     = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign done                     = (state_q == S_FIN);
    assign pass                     = pass_q;
    assign fail_count               = fc_q;
    assign first_fail_idx           = ffi_q;
    assign observed                 = obs_q;

endmodule

// File: tb/tb_dual_rail_vector_driver.sv
// Bench for dual_rail_vector_driver: a table-driven gate model answers the rails, and each sweep's
// timing, rail sequence and results are compared with values derived from the gate's boolean function.

module tb_dual_rail_vector_driver;

    localparam int unsigned SETTLE_CYC = 4;
`ifdef DRV_SYNC_EN
    localparam int P = SETTLE_CYC + 3;
`else
    localparam int P = SETTLE_CYC + 1;
`endif
    localparam int DONE_CYC = 1 + 16 * P;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        dut_out;
    logic        A, B, C, D;
    logic        notA, notB, notC, notD;
    logic        busy, done, pass;
    logic [4:0]  fail_count;
    logic [3:0]  first_fail_idx;
    logic [15:0] observed;

    logic [15:0] tbl;
    logic [15:0] gold;
    logic [3:0]  rails;
    logic [3:0]  nrails;
    int          n_checks = 0;
    int          n_fail = 0;
    int          rail_err = 0;
    int          done_cnt = 0;

    dual_rail_vector_driver #(
        .SETTLE_CYC (SETTLE_CYC),
        .GOLDEN     (16'hFC51)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .dut_out        (dut_out),
        .A              (A),
        .B              (B),
        .C              (C),
        .D              (D),
        .notA           (notA),
        .notB           (notB),
        .notC           (notC),
        .notD           (notD),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx),
        .observed       (observed)
    );

    always #5 clk = ~clk;

    assign rails   = {A, B, C, D};
    assign nrails  = {notA, notB, notC, notD};
    assign dut_out = tbl[rails];

    // Rail complementarity and done pulses are watched on every cycle.
    always @(negedge clk) begin
        if (nrails !== ~rails) rail_err++;
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic gate_f(input logic a, input logic b, input logic c, input logic d);
        return (a & c) | (a & b & ~c) | (b & ~d) | (~a & ~c & ~d);
    endfunction

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check(tag, 64'({rails, nrails, busy, done, pass, fail_count, first_fail_idx, observed}),
              64'({4'h0, 4'hF, 3'b000, 5'd0, 4'd0, 16'h0000}));
    endtask

    // Runs one sweep starting from idle at a negedge (that cycle is cycle 0).
    task automatic sweep(input logic [15:0] t, input bit poke, input string tag);
        int          done_at;
        int          ndone;
        int          rail_bad;
        logic [15:0] d;
        logic [3:0]  exp_r;
        tbl      = t;
        d        = t ^ gold;
        done_at  = -1;
        ndone    = 0;
        rail_bad = 0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy_c1"}, 64'(busy), 64'd1);
        for (int c = 1; c <= DONE_CYC + 1; c++) begin
            if (c <= 16 * P)        exp_r = 4'((c - 1) / P);
            else if (c == DONE_CYC) exp_r = 4'd15;
            else                    exp_r = 4'd0;
            if (rails !== exp_r) rail_bad++;
            if (done === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            if (c == DONE_CYC) begin
                check({tag, ".pass"}, 64'(pass), 64'(d == 16'h0000));
                check({tag, ".fail_count"}, 64'(fail_count), 64'($countones(d)));
                if (d != 16'h0000)
                    check({tag, ".first_fail"}, 64'(first_fail_idx), 64'(lowest_set(d)));
                check({tag, ".observed"}, 64'(observed), 64'(t));
            end
            start = poke && (c == 10 || c == DONE_CYC);
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, ".done_at"}, 64'(done_at), 64'(DONE_CYC));
        check({tag, ".done_pulses"}, 64'(ndone), 64'd1);
        check({tag, ".rail_seq_errs"}, 64'(rail_bad), 64'd0);
        check({tag, ".idle_after"}, 64'({busy, done}), 64'd0);
        check({tag, ".held"}, 64'({pass, fail_count, observed}),
              64'({(d == 16'h0000), 5'($countones(d)), t}));
    endtask

    initial begin
        logic [15:0] t;
        logic [15:0] pd;
        int          dc;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 16; i++) begin
            t = 16'(i);
            gold[i] = gate_f(t[3], t[2], t[1], t[0]);
        end
        tbl = gold;

        repeat (2) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("idle_after_reset");

        sweep(gold, 1'b1, "golden");
        sweep(16'h0000, 1'b0, "stuck0");
        sweep(~gold, 1'b0, "inverted");

        // Reset asserted while vector 7 is on the rails.
        tbl   = gold ^ 16'h0013;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7 * P + 1) @(negedge clk);
        check("rst_mid.rails_before", 64'(rails), 64'd7);
        dc    = done_cnt;
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid.async");
        @(negedge clk);
        check_reset("rst_mid.held");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid.no_done", 64'(done_cnt), 64'(dc));

        // Abort while vector 7 is on the rails; vectors 0..6 keep their partial results.
        t     = 16'($urandom);
        tbl   = t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7 * P + 1) @(negedge clk);
        check("abort.rails_before", 64'(rails), 64'd7);
        dc    = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        pd = (t ^ gold) & 16'h007F;
        check("abort.state", 64'({busy, done, pass, rails, nrails}), 64'({3'b000, 4'h0, 4'hF}));
        check("abort.fail_count", 64'(fail_count), 64'($countones(pd)));
        if (pd != 16'h0000)
            check("abort.first_fail", 64'(first_fail_idx), 64'(lowest_set(pd)));
        check("abort.observed", 64'(observed), 64'(t & 16'h007F));
        check("abort.no_done", 64'(done_cnt), 64'(dc));

        // abort together with start in IDLE keeps the block idle.
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_beats_start", 64'(busy), 64'd0);

        for (int k = 0; k < 3; k++) begin
            sweep(16'($urandom), 1'b0, "random");
        end
        sweep(gold, 1'b0, "golden_again");

        check("rail_complement_errs", 64'(rail_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
